// File: rtl/thread_pkg.sv
// Shared types for the hardware-thread fetch sequencer: thread ids, sequencer
// states and the default sequential PC increment.
package thread_pkg;

    localparam int unsigned DEFAULT_NUM_THREADS = 4;
    localparam int unsigned DEFAULT_TW          = $clog2(DEFAULT_NUM_THREADS);
    localparam int unsigned INSTR_BYTES_DEFAULT = 4;

    typedef logic [DEFAULT_TW-1:0] thread_id_t;

    typedef enum logic [0:0] {
        SEQ_INIT = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/thread_rr_picker.sv
// Combinational round-robin picker: first eligible thread strictly after rr_i,
// wrapping around, so the thread picked last time has the lowest priority.
module thread_rr_picker #(
    parameter int unsigned NUM_THREADS = 4,
    localparam int unsigned TW = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] eligible_i,
    input  logic [TW-1:0]          rr_i,
    output logic [TW-1:0]          pick_o,
    output logic                   found_o
);

    // search rr+1, rr+2, ... rr+NUM_THREADS (the last one is rr itself)
    always_comb begin
        logic [TW-1:0] idx;
        pick_o  = {TW{1'b0}};
        found_o = 1'b0;
        idx     = {TW{1'b0}};
        for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
            idx = TW'((32'(rr_i) + k) % NUM_THREADS);
            if (!found_o && eligible_i[idx]) begin
                found_o = 1'b1;
                pick_o  = idx;
            end else begin
                found_o = found_o;
                pick_o  = pick_o;
            end
        end
    end

endmodule

// File: rtl/thread_pc_sequencer.sv
// Fetch-side PC sequencer: initialises the per-thread PC store to the boot
// address, then issues one round-robin fetch per cycle with PC write-back.
module thread_pc_sequencer
    import thread_pkg::*;
#(
    parameter int unsigned NUM_THREADS = DEFAULT_NUM_THREADS,
    parameter int unsigned VLEN        = 64,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEFAULT,
    localparam int unsigned TW = $clog2(NUM_THREADS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [VLEN-1:0]        boot_addr_i,
    input  logic [NUM_THREADS-1:0] thread_active_i,
    input  logic [NUM_THREADS-1:0] thread_stall_i,
    input  logic                   redirect_valid_i,
    input  logic [TW-1:0]          redirect_thread_id_i,
    input  logic [VLEN-1:0]        redirect_pc_i,
    output logic [TW-1:0]          pc_read_thread_id_o,
    input  logic [VLEN-1:0]        pc_read_value_i,
    output logic                   pc_write_o,
    output logic [TW-1:0]          pc_write_thread_id_o,
    output logic [VLEN-1:0]        pc_write_value_o,
    output logic                   fetch_valid_o,
    input  logic                   fetch_ready_i,
    output logic [VLEN-1:0]        fetch_pc_o,
    output logic [TW-1:0]          fetch_thread_id_o,
    output logic                   init_done_o
);

    localparam logic [TW-1:0] LAST_ID = TW'(NUM_THREADS - 1);

    seq_state_e             state_q;
    logic [TW-1:0]          init_cnt_q;
    logic [TW-1:0]          rr_q;
    logic                   fetch_valid_q;
    logic [VLEN-1:0]        fetch_pc_q;
    logic [TW-1:0]          fetch_tid_q;

    logic [NUM_THREADS-1:0] eligible_s;
    logic [TW-1:0]          pick_s;
    logic                   found_s;
    logic                   slot_free_s;
    logic                   select_s;

    assign eligible_s  = thread_active_i & ~thread_stall_i;
    assign slot_free_s = ~fetch_valid_q | fetch_ready_i;
    // a redirect owns the single store write port, so it blocks selection
    assign select_s    = ~rst_i & (state_q == SEQ_RUN) & ~redirect_valid_i
                       & slot_free_s & found_s;

    thread_rr_picker #(
        .NUM_THREADS (NUM_THREADS)
    ) u_picker (
        .eligible_i (eligible_s),
        .rr_i       (rr_q),
        .pick_o     (pick_s),
        .found_o    (found_s)
    );

    assign pc_read_thread_id_o = select_s ? pick_s : rr_q;
    assign fetch_valid_o       = fetch_valid_q;
    assign fetch_pc_o          = fetch_pc_q;
    assign fetch_thread_id_o   = fetch_tid_q;
    assign init_done_o         = (state_q == SEQ_RUN);

    // PC store write port: boot fill, redirect target, or sequential increment
    always_comb begin
        pc_write_o           = 1'b0;
        pc_write_thread_id_o = {TW{1'b0}};
        pc_write_value_o     = {VLEN{1'b0}};
        if (rst_i) begin
            pc_write_o = 1'b0;
        end else if (state_q == SEQ_INIT) begin
            pc_write_o           = 1'b1;
            pc_write_thread_id_o = init_cnt_q;
            pc_write_value_o     = boot_addr_i;
        end else if (redirect_valid_i) begin
            pc_write_o           = 1'b1;
            pc_write_thread_id_o = redirect_thread_id_i;
            pc_write_value_o     = redirect_pc_i;
        end else if (select_s) begin
            pc_write_o           = 1'b1;
            pc_write_thread_id_o = pick_s;
            pc_write_value_o     = pc_read_value_i + VLEN'(INSTR_BYTES);
        end else begin
            pc_write_o = 1'b0;
        end
    end

    // sequencer FSM, round-robin pointer and the registered fetch slot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SEQ_INIT;
            init_cnt_q    <= {TW{1'b0}};
            rr_q          <= LAST_ID;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= {VLEN{1'b0}};
            fetch_tid_q   <= {TW{1'b0}};
        end else begin
            case (state_q)
                SEQ_INIT: begin
                    init_cnt_q <= init_cnt_q + TW'(1);
                    if (init_cnt_q == LAST_ID) begin
                        state_q <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (select_s) begin
                        fetch_valid_q <= 1'b1;
                        fetch_pc_q    <= pc_read_value_i;
                        fetch_tid_q   <= pick_s;
                        rr_q          <= pick_s;
                    end else if (fetch_valid_q && fetch_ready_i) begin
                        fetch_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SEQ_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_pc_sequencer.sv
// Bench for thread_pc_sequencer: an external PC store plus a per-thread PC
// reference model, driven by directed scenarios and then random traffic.
module tb_thread_pc_sequencer;

    localparam int N = 4;
    localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  active;
    logic [3:0]  stall;
    logic        redir;
    logic [1:0]  redir_tid;
    logic [63:0] redir_pc;
    logic [1:0]  pc_read_tid;
    logic [63:0] pc_read_val;
    logic        pc_write;
    logic [1:0]  pc_write_tid;
    logic [63:0] pc_write_val;
    logic        fetch_valid;
    logic        ready;
    logic [63:0] fetch_pc;
    logic [1:0]  fetch_tid;
    logic        init_done;

    logic [63:0] mem [N];

    int checks   = 0;
    int failures = 0;

    bit          m_known = 1'b0;
    bit          m_init;
    int          m_cnt;
    int          m_rr;
    bit          m_fv;
    logic [63:0] m_fpc;
    int          m_ftid;
    logic [63:0] exp_pc [N];

    always #5 clk = ~clk;

    assign pc_read_val = mem[pc_read_tid];

    thread_pc_sequencer #(
        .NUM_THREADS (4),
        .VLEN        (64),
        .INSTR_BYTES (4)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .boot_addr_i          (BOOT),
        .thread_active_i      (active),
        .thread_stall_i       (stall),
        .redirect_valid_i     (redir),
        .redirect_thread_id_i (redir_tid),
        .redirect_pc_i        (redir_pc),
        .pc_read_thread_id_o  (pc_read_tid),
        .pc_read_value_i      (pc_read_val),
        .pc_write_o           (pc_write),
        .pc_write_thread_id_o (pc_write_tid),
        .pc_write_value_o     (pc_write_val),
        .fetch_valid_o        (fetch_valid),
        .fetch_ready_i        (ready),
        .fetch_pc_o           (fetch_pc),
        .fetch_thread_id_o    (fetch_tid),
        .init_done_o          (init_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare against the model at the negedge, then let the
    // store commit the write and advance the model past the posedge.
    task automatic step();
        bit          ew;
        int          wid;
        logic [63:0] wval;
        bit          sel;
        bit          found;
        int          t;
        bit          c_w;
        logic [1:0]  c_id;
        logic [63:0] c_val;
        @(negedge clk);
        ew = 1'b0; wid = 0; wval = 64'd0; sel = 1'b0; found = 1'b0; t = 0;
        if (m_known) begin
            check("fetch_valid", {63'd0, fetch_valid}, {63'd0, m_fv});
            check("fetch_pc", fetch_pc, m_fpc);
            check("fetch_tid", {62'd0, fetch_tid}, 64'(m_ftid));
            check("init_done", {63'd0, init_done}, {63'd0, !m_init});
        end
        if (m_known || rst) begin
            if (rst) begin
                ew = 1'b0;
            end else if (m_init) begin
                ew = 1'b1; wid = m_cnt; wval = BOOT;
            end else if (redir) begin
                ew = 1'b1; wid = int'(redir_tid); wval = redir_pc;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (!found && active[c] && !stall[c]) begin
                        found = 1'b1;
                        t = c;
                    end
                end
                sel = found && (!m_fv || ready);
                if (sel) begin
                    ew = 1'b1; wid = t; wval = exp_pc[t] + 64'd4;
                end
            end
            check("pc_write", {63'd0, pc_write}, {63'd0, ew});
            if (ew) begin
                check("pc_write_tid", {62'd0, pc_write_tid}, 64'(wid));
                check("pc_write_val", pc_write_val, wval);
            end
            if (!rst && !m_init && !redir) begin
                check("pc_read_tid", {62'd0, pc_read_tid}, 64'(sel ? t : m_rr));
            end
        end
        c_w = pc_write; c_id = pc_write_tid; c_val = pc_write_val;
        @(posedge clk);
        #1;
        if (c_w === 1'b1) mem[c_id] = c_val;
        if (rst) begin
            m_known = 1'b1; m_init = 1'b1; m_cnt = 0; m_rr = N - 1;
            m_fv = 1'b0; m_fpc = 64'd0; m_ftid = 0;
        end else if (!m_known) begin
            m_known = 1'b0;
        end else if (m_init) begin
            exp_pc[m_cnt] = BOOT;
            m_cnt++;
            if (m_cnt == N) m_init = 1'b0;
        end else if (redir) begin
            exp_pc[int'(redir_tid)] = redir_pc;
            if (m_fv && ready) m_fv = 1'b0;
        end else if (sel) begin
            m_fv = 1'b1; m_fpc = exp_pc[t]; m_ftid = t; m_rr = t;
            exp_pc[t] = exp_pc[t] + 64'd4;
        end else if (m_fv && ready) begin
            m_fv = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; active = 4'b0000; stall = 4'b0000; ready = 1'b0;
        redir = 1'b0; redir_tid = 2'd0; redir_pc = 64'd0;
        step(); step();

        // reset release: four INIT cycles, first RUN cycle selects T0
        rst = 1'b0; active = 4'b1111; ready = 1'b1;
        for (int i = 0; i < N; i++) step();
        step();
        check("rr_first_tid", {62'd0, fetch_tid}, 64'd0);
        check("rr_first_pc", fetch_pc, 64'h0000_0000_8000_0000);
        step(); step(); step();
        check("rr_t3_tid", {62'd0, fetch_tid}, 64'd3);
        step();
        check("rr_wrap_tid", {62'd0, fetch_tid}, 64'd0);
        check("rr_wrap_pc", fetch_pc, 64'h0000_0000_8000_0004);

        // stall and mask
        stall = 4'b0010; active = 4'b1011;
        for (int i = 0; i < 6; i++) step();

        // backpressure
        stall = 4'b0000; active = 4'b1111;
        step(); step();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ready = 1'b1;
        step(); step();

        // redirect T1
        redir = 1'b1; redir_tid = 2'd1; redir_pc = 64'h0000_0000_8000_1000;
        step();
        redir = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // wrap of the sequential increment on T0
        active = 4'b0001;
        redir = 1'b1; redir_tid = 2'd0; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redir = 1'b0;
        step();
        check("wrap_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wrap_zero_pc", fetch_pc, 64'd0);

        // mid-stream reset, then INIT rewrites every slot
        active = 4'b1111;
        rst = 1'b1;
        step();
        check("midrst_valid", {63'd0, fetch_valid}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < N + 3; i++) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            active    = 4'($urandom);
            stall     = 4'($urandom & $urandom);
            ready     = ($urandom_range(0, 3) != 0);
            redir     = ($urandom_range(0, 7) == 0);
            redir_tid = 2'($urandom_range(0, 3));
            redir_pc  = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; redir = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
